// File: rtl/mips_mem_arbiter.sv
// Arbitrates one single-ported memory between the IF fetch port and the MEM load/store port.
// Data wins by default; a run counter hands the memory to fetch after MAX_DM_RUN data grants.
module mips_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int MAX_DM_RUN = 4
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam int RUN_W = (MAX_DM_RUN < 1) ? 1 : $clog2(MAX_DM_RUN + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              owner_dm_q, owner_dm_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              if_gnt_q, if_gnt_d;
  logic              dm_gnt_q, dm_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              dm_rvalid_q, dm_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              pick_dm;

  always_comb begin
    state_d     = state_q;
    owner_dm_d  = owner_dm_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    run_d       = run_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    pick_dm     = dm_req && !(if_req && (run_q == RUN_W'(MAX_DM_RUN)));

    case (state_q)
      S_IDLE: begin
        // The completion cycle (rvalid high) does not arbitrate, giving a MEM_LAT+3 period.
        if (!(if_rvalid_q || dm_rvalid_q) && (if_req || dm_req)) begin
          state_d  = S_ISSUE;
          busy_d   = 1'b1;
          mem_en_d = 1'b1;
          if (pick_dm) begin
            owner_dm_d  = 1'b1;
            we_d        = dm_we;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            dm_gnt_d    = 1'b1;
            if (run_q != RUN_W'(MAX_DM_RUN)) run_d = run_q + RUN_W'(1);
          end else begin
            owner_dm_d = 1'b0;
            we_d       = 1'b0;
            mem_addr_d = if_addr;
            if_gnt_d   = 1'b1;
            run_d      = '0;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = CNT_W'(MEM_LAT);
        busy_d  = 1'b1;
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          if (owner_dm_q) begin
            dm_rvalid_d = 1'b1;
            if (!we_q) dm_rdata_d = mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_dm_q  <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      run_q       <= '0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_dm_q  <= owner_dm_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      run_q       <= run_d;
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign dm_gnt    = dm_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: a MEM_LAT=1 instance checked through a completion
// scoreboard plus cycle-exact probes, and a MEM_LAT=3 instance for the latency case.
module tb_mips_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // MEM_LAT=1 instance
  logic        if_req, if_gnt, if_rvalid, dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [9:0]  if_addr, dm_addr, mem_addr;
  logic [31:0] if_rdata, dm_wdata, dm_rdata, mem_wdata, mem_rdata;
  logic        mem_en, mem_we, busy;
  // MEM_LAT=3 instance
  logic        if_req3, if_gnt3, if_rvalid3, dm_gnt3, dm_rvalid3;
  logic [9:0]  if_addr3, mem_addr3;
  logic [31:0] if_rdata3, dm_rdata3, mem_wdata3, mem_rdata3;
  logic        mem_en3, mem_we3, busy3;
  logic        dm_req3, dm_we3;
  logic [9:0]  dm_addr3;
  logic [31:0] dm_wdata3;

  mips_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1), .MAX_DM_RUN(4)) u_dut (
    .clk1(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mips_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(3), .MAX_DM_RUN(4)) u_dut3 (
    .clk1(clk), .rst(rst),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .dm_req(dm_req3), .dm_we(dm_we3), .dm_addr(dm_addr3), .dm_wdata(dm_wdata3),
    .dm_gnt(dm_gnt3), .dm_rvalid(dm_rvalid3), .dm_rdata(dm_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
  );

  function automatic logic [31:0] init_val(input int i);
    return 32'hA5C3_0000 ^ (i * 32'h0001_0101);
  endfunction

  // Memory models: read data is garbage except MEM_LAT cycles after an enabled access.
  logic [31:0] mem1 [0:1023];
  logic [31:0] mem3 [0:1023];
  logic [31:0] sh1  [0:1023];
  logic [31:0] p0, p1, p2;

  always @(posedge clk) begin
    if (mem_en && mem_we) mem1[mem_addr] <= mem_wdata;
    mem_rdata <= mem_en ? mem1[mem_addr] : 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    p0 <= mem_en3 ? mem3[mem_addr3] : 32'hDEAD_BEEF;
    p1 <= p0;
    p2 <= p1;
  end
  assign mem_rdata3 = p2;

  typedef struct { logic st; logic [31:0] data; } exp_t;
  logic [31:0] if_q [$];
  exp_t        dm_q [$];
  logic [31:0] last_load;

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    if_req  = 1'b0; dm_req = 1'b0; if_req3 = 1'b0;
    if_q.delete();
    dm_q.delete();
    last_load = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_dm(input logic we, input logic [9:0] addr, input logic [31:0] wd);
    exp_t e;
    e.st   = we;
    e.data = we ? 32'h0 : sh1[addr];
    if (we) sh1[addr] = wd;
    dm_q.push_back(e);
    dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wd;
    tick();
    for (int k = 0; k < 20 && !dm_gnt; k++) tick();
    chk("dm_gnt_wait", {31'b0, dm_gnt}, 32'd1);
    dm_req = 1'b0;
    repeat (5) tick();
  endtask

  // Completion scoreboard plus grant exclusivity
  always @(negedge clk) begin
    if (!rst) begin
      if (if_gnt || dm_gnt) chk("gnt_exclusive", {31'b0, if_gnt & dm_gnt}, 32'd0);
      if (if_rvalid) begin
        if (if_q.size() == 0) chk("if_rvalid_unexpected", {31'b0, if_rvalid}, 32'd0);
        else chk("if_rdata_sb", if_rdata, if_q.pop_front());
      end
      if (dm_rvalid) begin
        if (dm_q.size() == 0) chk("dm_rvalid_unexpected", {31'b0, dm_rvalid}, 32'd0);
        else begin
          exp_t e;
          e = dm_q.pop_front();
          if (e.st) chk("dm_rdata_store_hold", dm_rdata, last_load);
          else begin
            chk("dm_rdata_sb", dm_rdata, e.data);
            last_load = e.data;
          end
        end
      end
    end
  end

  logic [9:0] seq;
  int         ngnt;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = init_val(i);
      sh1[i]  = init_val(i);
      mem3[i] = init_val(i);
    end
    mem1[5] = 32'h2842_0005;
    sh1[5]  = 32'h2842_0005;
    dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; if_addr = '0; if_addr3 = '0;
    dm_req3 = 1'b0; dm_we3 = 1'b0; dm_addr3 = '0; dm_wdata3 = '0;
    do_reset();

    // Reset state
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    chk("rst_gnts", {30'b0, if_gnt, dm_gnt}, 32'd0);

    // Single fetch, MEM_LAT=1
    if_q.push_back(sh1[5]);
    if_req = 1'b1; if_addr = 10'd5;
    tick();
    chk("t1_if_gnt_c1", {31'b0, if_gnt}, 32'd1);
    chk("t1_mem_en_c1", {31'b0, mem_en}, 32'd1);
    chk("t1_mem_we_c1", {31'b0, mem_we}, 32'd0);
    chk("t1_mem_addr_c1", {22'b0, mem_addr}, 32'd5);
    chk("t1_busy_c1", {31'b0, busy}, 32'd1);
    if_req = 1'b0;
    tick();
    chk("t1_busy_c2", {31'b0, busy}, 32'd1);
    chk("t1_mem_en_c2", {31'b0, mem_en}, 32'd0);
    chk("t1_if_rvalid_c2", {31'b0, if_rvalid}, 32'd0);
    tick();
    chk("t1_if_rvalid_c3", {31'b0, if_rvalid}, 32'd1);
    chk("t1_if_rdata_c3", if_rdata, 32'h2842_0005);
    chk("t1_busy_c3", {31'b0, busy}, 32'd0);
    tick();
    chk("t1_if_rvalid_c4", {31'b0, if_rvalid}, 32'd0);
    chk("t1_if_rdata_hold", if_rdata, 32'h2842_0005);

    // Simultaneous fetch and load: data first
    dm_q.push_back('{1'b0, sh1[10'h20]});
    if_q.push_back(sh1[3]);
    if_req = 1'b1; if_addr = 10'd3;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h20;
    tick();
    chk("t2_dm_gnt_c1", {31'b0, dm_gnt}, 32'd1);
    chk("t2_if_gnt_c1", {31'b0, if_gnt}, 32'd0);
    dm_req = 1'b0;
    tick();
    tick();
    chk("t2_dm_rvalid_c3", {31'b0, dm_rvalid}, 32'd1);
    tick();
    chk("t2_if_gnt_c4", {31'b0, if_gnt}, 32'd0);
    tick();
    chk("t2_if_gnt_c5", {31'b0, if_gnt}, 32'd1);
    if_req = 1'b0;
    tick();
    tick();
    chk("t2_if_rvalid_c7", {31'b0, if_rvalid}, 32'd1);
    tick();

    // Store then load the same word
    dm_q.push_back('{1'b1, 32'h0});
    sh1[10'h30] = 32'h0000_00AB;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h30; dm_wdata = 32'h0000_00AB;
    tick();
    chk("t4_dm_gnt", {31'b0, dm_gnt}, 32'd1);
    chk("t4_mem_we_issue", {31'b0, mem_we}, 32'd1);
    chk("t4_mem_wdata", mem_wdata, 32'h0000_00AB);
    chk("t4_mem_addr", {22'b0, mem_addr}, 32'h30);
    dm_req = 1'b0; dm_we = 1'b0;
    tick();
    chk("t4_mem_we_wait", {31'b0, mem_we}, 32'd0);
    tick();
    chk("t4_dm_rvalid", {31'b0, dm_rvalid}, 32'd1);
    tick();
    do_dm(1'b0, 10'h30, 32'h0);
    chk("t4_load_back", dm_rdata, 32'h0000_00AB);

    // Continuous contention: fetch gets every fifth grant
    do_reset();
    seq = '0; ngnt = 0;
    if_req = 1'b1; if_addr = 10'd100;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd200;
    for (int k = 0; k < 100 && ngnt < 10; k++) begin
      tick();
      if (if_gnt) begin
        if_q.push_back(sh1[if_addr]);
        seq[ngnt] = 1'b1;
        ngnt++;
        if_addr = if_addr + 10'd1;
      end
      if (dm_gnt) begin
        dm_q.push_back('{1'b0, sh1[dm_addr]});
        ngnt++;
        dm_addr = dm_addr + 10'd1;
      end
      if (ngnt >= 10) begin
        if_req = 1'b0; dm_req = 1'b0;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    chk("t3_grant_count", ngnt, 32'd10);
    chk("t3_grant_order", {22'b0, seq}, 32'b10_0001_0000);
    repeat (6) tick();

    // MEM_LAT=3 instance
    do_reset();
    if_req3 = 1'b1; if_addr3 = 10'd7;
    tick();
    chk("t5_if_gnt_c1", {31'b0, if_gnt3}, 32'd1);
    chk("t5_busy_c1", {31'b0, busy3}, 32'd1);
    if_req3 = 1'b0;
    tick();
    if_req3 = 1'b1; if_addr3 = 10'd8;
    for (int c = 2; c <= 4; c++) begin
      chk($sformatf("t5_busy_c%0d", c), {31'b0, busy3}, 32'd1);
      chk($sformatf("t5_if_rvalid_c%0d", c), {31'b0, if_rvalid3}, 32'd0);
      chk($sformatf("t5_if_gnt_c%0d", c), {31'b0, if_gnt3}, 32'd0);
      tick();
    end
    chk("t5_if_rvalid_c5", {31'b0, if_rvalid3}, 32'd1);
    chk("t5_if_rdata_c5", if_rdata3, init_val(7));
    chk("t5_busy_c5", {31'b0, busy3}, 32'd0);
    tick();
    chk("t5_if_gnt_c6", {31'b0, if_gnt3}, 32'd0);
    tick();
    chk("t5_if_gnt_c7", {31'b0, if_gnt3}, 32'd1);
    chk("t5_mem_addr_c7", {22'b0, mem_addr3}, 32'd8);
    if_req3 = 1'b0;
    repeat (6) tick();

    // Reset during WAIT of a fetch aborts it
    if_q.push_back(sh1[9]);
    if_req = 1'b1; if_addr = 10'd9;
    tick();
    chk("t6_if_gnt_c1", {31'b0, if_gnt}, 32'd1);
    if_req = 1'b0;
    tick();
    rst = 1'b1;
    if_q.delete();
    dm_q.delete();
    last_load = '0;
    tick();
    rst = 1'b0;
    chk("t6_busy_after_rst", {31'b0, busy}, 32'd0);
    chk("t6_if_rvalid_after_rst", {31'b0, if_rvalid}, 32'd0);
    chk("t6_if_rdata_after_rst", if_rdata, 32'd0);
    chk("t6_mem_addr_after_rst", {22'b0, mem_addr}, 32'd0);
    dm_q.push_back('{1'b0, sh1[10'h21]});
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h21;
    tick();
    chk("t6_dm_gnt", {31'b0, dm_gnt}, 32'd1);
    dm_req = 1'b0;
    tick();
    chk("t6_if_rvalid_none", {31'b0, if_rvalid}, 32'd0);
    tick();
    chk("t6_dm_rvalid", {31'b0, dm_rvalid}, 32'd1);
    chk("t6_dm_rdata", dm_rdata, sh1[10'h21]);
    repeat (4) tick();

    chk("end_if_q_drained", if_q.size(), 32'd0);
    chk("end_dm_q_drained", dm_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
